// File: rtl/pc_gen_unit.sv
// Program-counter generator for the fetch stage.
// Holds the fetch PC, advances it by STEP on each accepted, unstalled fetch,
// and applies trap / redirect updates with trap > redirect > advance > hold.
// A small BOOT/RUN/HALT FSM gates the fetch request.
//
// Handshake: a fetch is accepted in any cycle where o_pc_valid and
// i_fetch_ready are both high at the rising edge; o_pc_valid depends only on
// registered state, never combinationally on i_fetch_ready.
module pc_gen_unit #(
    parameter int unsigned XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int unsigned STEP         = 4,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             i_clk,
    input  logic             in_rst,
    input  logic             i_stall,
    input  logic             i_fetch_ready,
    input  logic             i_redirect_valid,
    input  logic [XLEN-1:0]  i_redirect_pc,
    input  logic             i_trap_valid,
    input  logic [XLEN-1:0]  i_trap_vector,
    input  logic             i_halt,
    input  logic             i_resume,
    output logic [XLEN-1:0]  o_pc,
    output logic             o_pc_valid,
    output logic [XLEN-1:0]  o_pc_next_seq,
    output logic             o_misalign,
    output logic             o_halted,
    output logic [CNT_W-1:0] o_fetch_cnt,
    output logic [1:0]       o_state
);

    localparam int unsigned AB = $clog2(STEP);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic            active;
    logic            take_trap;
    logic            redir_req;
    logic            redir_aligned;
    logic            take_redir;
    logic            drop_redir;
    logic            accept;
    logic            advance;
    logic [XLEN-1:0] trap_target;
    logic [XLEN-1:0] pc_nxt;

    // BOOT ignores every request; trap and redirect are honoured in RUN and HALT.
    always_comb begin
        active        = (state != ST_BOOT);
        take_trap     = active & i_trap_valid;
        redir_req     = active & i_redirect_valid & ~take_trap;
        redir_aligned = (i_redirect_pc[AB-1:0] == '0);
        take_redir    = redir_req & redir_aligned;
        drop_redir    = redir_req & ~redir_aligned;
        accept        = o_pc_valid & i_fetch_ready;
        advance       = accept & ~i_stall;
        trap_target   = {i_trap_vector[XLEN-1:AB], {AB{1'b0}}};
    end

    // Next PC in priority order; a dropped redirect falls through to advance.
    always_comb begin
        pc_nxt = o_pc;
        if (take_trap) begin
            pc_nxt = trap_target;
        end else if (take_redir) begin
            pc_nxt = i_redirect_pc;
        end else if (advance) begin
            pc_nxt = o_pc + XLEN'(STEP);
        end
    end

    // State register.
    always_ff @(posedge i_clk or negedge in_rst) begin
        if (!in_rst) begin
            state <= ST_BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: halt beats resume; a trap always pulls HALT back to RUN.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_BOOT: state_nxt = ST_RUN;
            ST_RUN: begin
                if (i_halt) begin
                    state_nxt = ST_HALT;
                end
            end
            ST_HALT: begin
                if (i_trap_valid || (i_resume && !i_halt)) begin
                    state_nxt = ST_RUN;
                end
            end
            default: state_nxt = ST_BOOT;
        endcase
    end

    // FSM outputs are decoded from the registered state only.
    always_comb begin
        o_pc_valid = (state == ST_RUN);
        o_halted   = (state == ST_HALT);
        o_state    = state;
    end

    // PC, misalign pulse and fetch counter registers.
    always_ff @(posedge i_clk or negedge in_rst) begin
        if (!in_rst) begin
            o_pc        <= RESET_VECTOR;
            o_misalign  <= 1'b0;
            o_fetch_cnt <= '0;
        end else begin
            o_pc       <= pc_nxt;
            o_misalign <= drop_redir;
            if (accept) begin
                o_fetch_cnt <= o_fetch_cnt + CNT_W'(1);
            end
        end
    end

    // Sequential successor of the current PC, wrapping modulo 2^XLEN.
    always_comb begin
        o_pc_next_seq = o_pc + XLEN'(STEP);
    end

endmodule
